// File: rtl/uart_tx.sv
// UART transmitter: pops one word from the TX FIFO and sends it as
// start / D_W data bits (LSB first) / optional even parity / stop bit(s).
module uart_tx #(
  parameter int D_W       = 8,
  parameter int B_TICK    = 16,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_tick,
  input  logic           tx_en,
  input  logic           fifo_empty,
  input  logic [D_W-1:0] fifo_data,
  output logic           fifo_rd_en,
  output logic           txd,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int TICK_W = $clog2(B_TICK) + 1;
  localparam int BIT_W  = $clog2(D_W) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  localparam logic [2:0]        S_AFTER_DATA = (PARITY_EN != 0) ? S_PARITY : S_STOP;
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(B_TICK - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST    = BIT_W'(D_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST    = BIT_W'(STOP_BITS - 1);

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [D_W-1:0]    sh_q, sh_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              bit_end;

  assign bit_end = baud_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    par_d      = par_q;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;

    // Ticks only advance once a frame is on the wire.
    if (state_q >= S_START && baud_tick)
      tick_d = bit_end ? '0 : tick_q + TICK_W'(1);

    case (state_q)
      S_IDLE: begin
        if (rst && tx_en && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        sh_d    = fifo_data;
        par_d   = ^fifo_data;
        tick_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = S_AFTER_DATA;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            tx_done = 1'b1;
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so txd lines up with state_q.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = sh_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (state_q != S_IDLE) || fifo_rd_en;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: instance 0 is 8N1, instance 1 is 8E2; both share clock,
// reset, baud strobe and tx_en, each with its own FIFO and frame-level model.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, baud_tick, tx_en;
  logic [1:0] empty, rd, txd, busy, done;
  logic [7:0] fd [2];
  logic [7:0] mem [2][16];
  int         wp [2];
  int         rp [2];
  int         cyc;
  int         n_chk, n_fail;

  assign empty[0] = (rp[0] == wp[0]);
  assign empty[1] = (rp[1] == wp[1]);

  uart_tx #(.D_W(8), .B_TICK(16), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
    .fifo_empty(empty[0]), .fifo_data(fd[0]), .fifo_rd_en(rd[0]),
    .txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx #(.D_W(8), .B_TICK(16), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
    .fifo_empty(empty[1]), .fifo_data(fd[1]), .fifo_rd_en(rd[1]),
    .txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  // FIFO read data appears the cycle after the pop strobe.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (rd[i]) begin
        fd[i] <= mem[i][rp[i] % 16];
        rp[i] <= rp[i] + 1;
      end

  // Free-running baud strobe, one clk in four.
  initial begin
    cyc = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      baud_tick = (cyc % 4 == 0);
    end
  end

  // Frame model: a frame is a list of line levels, each held for 16 ticks.
  // Instance i has parity = i and stop bits = i+1.
  int         ph [2];
  int         idx [2];
  int         tk [2];
  int         nb [2];
  logic [11:0] fb [2];

  function automatic logic [11:0] frame(input logic [7:0] d, input int i);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (i == 1) f[9] = ^d;
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] <= 0; idx[i] <= 0; tk[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        case (ph[i])
          0: if (tx_en && !empty[i]) ph[i] <= 1;
          1: begin
            fb[i] <= frame(fd[i], i);
            nb[i] <= 10 + 2 * i;
            idx[i] <= 0; tk[i] <= 0; ph[i] <= 2;
          end
          default: if (baud_tick) begin
            if (tk[i] == 15) begin
              tk[i] <= 0;
              if (idx[i] == nb[i] - 1) ph[i] <= 0;
              else idx[i] <= idx[i] + 1;
            end else tk[i] <= tk[i] + 1;
          end
        endcase
    end
  end

  function automatic logic [3:0] expv(input int i);
    logic rdx, bx, dx, tx;
    rdx = rst && ph[i] == 0 && tx_en && !empty[i];
    bx  = (ph[i] != 0) || rdx;
    dx  = ph[i] == 2 && baud_tick && tk[i] == 15 && idx[i] == nb[i] - 1;
    tx  = (ph[i] == 2) ? fb[i][idx[i]] : 1'b1;
    return {tx, rdx, bx, dx};
  endfunction

  int rd_cnt [2];
  int done_cnt [2];
  int busy_cnt [2];
  int low_cnt [2];
  int last_done [2];
  int last_gap [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] act, e;
      act = {txd[i], rd[i], busy[i], done[i]};
      e   = expv(i);
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL model[%0d] cyc %0d: txd/rd/busy/done got %b expected %b", i, cyc, act, e);
      end
      if (rd[i])   begin rd_cnt[i]++; last_gap[i] = cyc - last_done[i]; end
      if (done[i]) begin done_cnt[i]++; last_done[i] = cyc; end
      if (busy[i]) busy_cnt[i]++;
      if (txd[i] !== 1'b1) low_cnt[i]++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d);
    mem[i][wp[i] % 16] = d;
    wp[i]++;
  endtask

  // which: 0 waits on pop count, 1 on done count.
  task automatic wait_for(input int i, input int which, input int target, input string nm);
    int k = 0;
    while (((which == 0) ? rd_cnt[i] : done_cnt[i]) < target && k < 4000) begin
      step(1); k++;
    end
    if (k >= 4000) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for count %0d", nm, target);
    end
  endtask

  task automatic wait_start(input int i);
    int k = 0;
    while (txd[i] !== 1'b0 && k < 4000) begin @(negedge clk); k++; end
    if (k >= 4000) begin
      n_chk++; n_fail++;
      $display("FAIL start_bit[%0d]: timeout, txd never went low", i);
    end
  endtask

  // Samples each bit at its centre, assuming 64-clk bits after the start edge.
  task automatic sample_frame(input int i, input int n, output logic [11:0] got);
    got = '1;
    wait_start(i);
    repeat (32) @(negedge clk);
    got[0] = txd[i];
    for (int b = 1; b < n; b++) begin
      repeat (64) @(negedge clk);
      got[b] = txd[i];
    end
  endtask

  logic [11:0] got0, got1;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; tx_en = 1'b0;
    step(3);
    chk("reset txd0", txd[0], 1);
    chk("reset txd1", txd[1], 1);
    chk("reset busy0", busy[0], 0);
    chk("reset rd0", rd[0], 0);
    chk("reset done0", done[0], 0);
    rst = 1'b1;
    step(1);

    // Empty FIFO with tx_en high: the line must stay idle.
    tx_en = 1'b1;
    step(1000);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle rd%0d", i), rd_cnt[i], 0);
      chk($sformatf("idle done%0d", i), done_cnt[i], 0);
      chk($sformatf("idle busy%0d", i), busy_cnt[i], 0);
      chk($sformatf("idle low%0d", i), low_cnt[i], 0);
    end

    // 0xA5 as 8N1 and 0x07 as 8E2, sent concurrently.
    push(0, 8'hA5);
    push(1, 8'h07);
    fork
      sample_frame(0, 10, got0);
      sample_frame(1, 12, got1);
    join
    chk("frame A5 8N1", int'(got0), 12'hF4A);
    chk("frame 07 8E2", int'(got1), 12'hE0E);
    wait_for(0, 1, 1, "done A5");
    wait_for(1, 1, 1, "done 07");
    chk("pops A5", rd_cnt[0], 1);
    chk("dones A5", done_cnt[0], 1);
    chk("pops 07", rd_cnt[1], 1);
    chk("dones 07", done_cnt[1], 1);
    step(5);

    // Back-to-back frames: second pop one clk after the first done.
    push(0, 8'h55);
    push(0, 8'h0F);
    wait_for(0, 1, 3, "done 55/0F");
    chk("b2b pops", rd_cnt[0], 3);
    chk("b2b dones", done_cnt[0], 3);
    chk("b2b gap", last_gap[0], 1);
    step(5);

    // Reset in the middle of data bit 3 of 0xFF.
    push(0, 8'hFF);
    wait_start(0);
    repeat (288) @(posedge clk);
    #1;
    chk("pre-reset busy", busy[0], 1);
    rst = 1'b0;
    #1;
    chk("abort txd", txd[0], 1);
    chk("abort busy", busy[0], 0);
    chk("abort rd", rd[0], 0);
    step(4);
    rst = 1'b1;
    step(200);
    chk("abort dones", done_cnt[0], 3);
    chk("abort pops", rd_cnt[0], 4);
    chk("abort idle busy", busy[0], 0);

    // tx_en dropped during START with two entries queued.
    push(0, 8'h3C);
    push(0, 8'hC3);
    wait_for(0, 0, 5, "pop 3C");
    step(10);
    tx_en = 1'b0;
    wait_for(0, 1, 4, "done 3C");
    step(100);
    chk("gated pops", rd_cnt[0], 5);
    chk("gated dones", done_cnt[0], 4);
    tx_en = 1'b1;
    #1;
    chk("reenable rd", rd[0], 1);
    wait_for(0, 1, 5, "done C3");
    chk("final pops", rd_cnt[0], 6);
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
